// File: rtl/storage_arbiter_pkg.sv
// Shared state, response and address-region definitions for the storage arbiter.
package storage_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRAM_ACC,
        ST_EXT_ACC,
        ST_RESP,
        ST_PROG
    } arb_state_e;

    typedef enum logic [1:0] {
        RGN_SRAM,
        RGN_EXT,
        RGN_ERR
    } region_e;

    // Response data is held at the widest supported bus; the top keeps only MEM_W bits.
    localparam int unsigned RSP_DATA_MAX = 512;

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
    } rsp_t;

    function automatic region_e decode_region(
        input logic [31:0] addr,
        input logic [32:0] sram_lim,
        input logic [32:0] mem_lim
    );
        if ({1'b0, addr} < sram_lim) return RGN_SRAM;
        if ({1'b0, addr} < mem_lim)  return RGN_EXT;
        return RGN_ERR;
    endfunction

endpackage

// File: rtl/storage_arbiter_timeout.sv
// Cycle counter for an outstanding external access; expire flags the LIMIT-th enabled cycle.
// load clears the count, the count saturates at LIMIT-1.
module ext_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(LIMIT - 1));
    assign expire     = enable && w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (enable && !w_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// One-outstanding-request arbiter between interleaved scratchpad banks and an external QSPI engine.
// Scratchpad responds 2 cycles after acceptance, range errors 1 cycle; req_ready stays low until the response is taken.
module storage_arbiter
    import storage_arbiter_pkg::*;
#(
    parameter int unsigned MEM_W       = 32,
    parameter int unsigned MEM_SZ      = 262144,
    parameter int unsigned SRAM_WORDS  = 2048,
    parameter int unsigned SRAM_BANKS  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [31:0]                    req_addr,
    input  logic [MEM_W-1:0]               req_wdata,
    input  logic [MEM_W/8-1:0]             req_be,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [MEM_W-1:0]               rsp_rdata,
    output logic                           rsp_err,
    input  logic                           prog_set,
    input  logic                           prog_clr,
    output logic                           prog_active,
    output logic [SRAM_BANKS-1:0]          bank_cen,
    output logic                           bank_gwen,
    output logic [MEM_W/8-1:0]             bank_wen,
    output logic [$clog2(SRAM_WORDS)-1:0]  bank_addr,
    output logic [MEM_W-1:0]               bank_d,
    input  logic [SRAM_BANKS*MEM_W-1:0]    bank_q,
    output logic                           ext_sel,
    output logic                           ext_write,
    output logic [31:0]                    ext_addr,
    output logic [MEM_W-1:0]               ext_wdata,
    input  logic                           ext_ready,
    input  logic [MEM_W-1:0]               ext_rdata
);

    localparam int unsigned BYTES    = MEM_W / 8;
    localparam int unsigned BYTE_SH  = $clog2(BYTES);
    localparam int unsigned BANK_SH  = $clog2(SRAM_BANKS);
    localparam int unsigned BANK_W   = (SRAM_BANKS > 1) ? BANK_SH : 1;
    localparam int unsigned ADDR_W   = $clog2(SRAM_WORDS);
    localparam logic [32:0] SRAM_LIM = 33'(SRAM_BANKS * SRAM_WORDS * BYTES);
    localparam logic [32:0] MEM_LIM  = 33'(MEM_SZ);

    arb_state_e            r_state;
    rsp_t                  r_rsp;
    logic                  r_rsp_valid;
    logic                  r_rsp_from_bank;
    logic                  r_req_ready;
    logic                  r_prog_active;
    logic                  r_prog_pend;
    logic                  r_write;
    logic [MEM_W-1:0]      r_wdata;
    logic [31:0]           r_ext_addr;
    logic                  r_ext_sel;
    logic                  r_ext_write;
    logic [BANK_W-1:0]     r_bank;
    logic [SRAM_BANKS-1:0] r_bank_cen;
    logic                  r_bank_gwen;
    logic [BYTES-1:0]      r_bank_wen;
    logic [ADDR_W-1:0]     r_bank_addr;
    logic [MEM_W-1:0]      r_bank_d;

    logic [31:0]           w_word;
    logic [BANK_W-1:0]     w_bank_idx;
    logic [ADDR_W-1:0]     w_bank_word;
    region_e               w_region;
    logic                  w_accept;
    logic                  w_set_req;
    logic                  w_expire;
    logic [MEM_W-1:0]      w_bank_rd;

    assign w_word      = req_addr >> BYTE_SH;
    assign w_bank_idx  = BANK_W'(w_word & 32'(SRAM_BANKS - 1));
    assign w_bank_word = ADDR_W'(w_word >> BANK_SH);
    assign w_region    = decode_region(req_addr, SRAM_LIM, MEM_LIM);
    assign w_accept    = req_valid && r_req_ready;
    assign w_set_req   = prog_set && !prog_clr;

    always_comb begin
        w_bank_rd = '0;
        for (int b = 0; b < SRAM_BANKS; b++) begin
            if (BANK_W'(b) == r_bank) w_bank_rd = bank_q[b*MEM_W +: MEM_W];
        end
    end

    ext_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .enable ((r_state == ST_EXT_ACC) && !ext_ready),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rsp           <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_from_bank <= 1'b0;
            r_req_ready     <= 1'b1;
            r_prog_active   <= 1'b0;
            r_prog_pend     <= 1'b0;
            r_write         <= 1'b0;
            r_wdata         <= '0;
            r_ext_addr      <= '0;
            r_ext_sel       <= 1'b0;
            r_ext_write     <= 1'b0;
            r_bank          <= '0;
            r_bank_cen      <= '1;
            r_bank_gwen     <= 1'b1;
            r_bank_wen      <= '1;
            r_bank_addr     <= '0;
            r_bank_d        <= '0;
        end else begin
            // Banks are driven for exactly one cycle; every other cycle they fall back to idle.
            r_bank_cen  <= '1;
            r_bank_gwen <= 1'b1;
            r_bank_wen  <= '1;
            r_bank_addr <= '0;
            r_bank_d    <= '0;

            if (r_state inside {ST_SRAM_ACC, ST_EXT_ACC, ST_RESP}) begin
                if (prog_clr)      r_prog_pend <= 1'b0;
                else if (prog_set) r_prog_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_wdata     <= req_wdata;
                        r_ext_addr  <= w_word;
                        r_bank      <= w_bank_idx;
                        if (w_set_req) r_prog_pend <= 1'b1;
                        case (w_region)
                            RGN_SRAM: begin
                                r_state     <= ST_SRAM_ACC;
                                r_bank_cen  <= ~(SRAM_BANKS'(1) << w_bank_idx);
                                r_bank_gwen <= ~req_write;
                                r_bank_wen  <= req_write ? ~req_be : '1;
                                r_bank_addr <= w_bank_word;
                                r_bank_d    <= req_write ? req_wdata : '0;
                            end
                            RGN_EXT: begin
                                r_state     <= ST_EXT_ACC;
                                r_ext_sel   <= 1'b1;
                                r_ext_write <= req_write;
                            end
                            default: begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp.rdata <= '0;
                                r_rsp.err   <= 1'b1;
                            end
                        endcase
                    end else if (w_set_req) begin
                        r_state       <= ST_PROG;
                        r_req_ready   <= 1'b0;
                        r_prog_active <= 1'b1;
                    end
                end
                ST_SRAM_ACC: begin
                    r_state         <= ST_RESP;
                    r_rsp_valid     <= 1'b1;
                    r_rsp           <= '0;
                    r_rsp_from_bank <= !r_write;
                end
                ST_EXT_ACC: begin
                    if (ext_ready || w_expire) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_ext_sel   <= 1'b0;
                        r_ext_write <= 1'b0;
                        r_rsp.rdata <= (ext_ready && !r_write) ? RSP_DATA_MAX'(ext_rdata) : '0;
                        r_rsp.err   <= !ext_ready;
                    end
                end
                ST_RESP: begin
                    // Read data is passed straight from the bank on the first response cycle, then held.
                    if (r_rsp_from_bank) begin
                        r_rsp.rdata     <= RSP_DATA_MAX'(w_bank_rd);
                        r_rsp_from_bank <= 1'b0;
                    end
                    if (rsp_ready) begin
                        r_rsp_valid     <= 1'b0;
                        r_rsp           <= '0;
                        r_rsp_from_bank <= 1'b0;
                        r_prog_pend     <= 1'b0;
                        if ((r_prog_pend || prog_set) && !prog_clr) begin
                            r_state       <= ST_PROG;
                            r_prog_active <= 1'b1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_req_ready <= 1'b1;
                        end
                    end
                end
                ST_PROG: begin
                    if (prog_clr) begin
                        r_state       <= ST_IDLE;
                        r_prog_active <= 1'b0;
                        r_req_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    if (MEM_W < RSP_DATA_MAX) begin : g_rsp_pad
        logic w_unused_rsp_pad;
        assign w_unused_rsp_pad = ^r_rsp.rdata[RSP_DATA_MAX-1:MEM_W];
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp.err;
    assign rsp_rdata   = r_rsp_from_bank ? w_bank_rd : r_rsp.rdata[MEM_W-1:0];
    assign prog_active = r_prog_active;
    assign bank_cen    = r_bank_cen;
    assign bank_gwen   = r_bank_gwen;
    assign bank_wen    = r_bank_wen;
    assign bank_addr   = r_bank_addr;
    assign bank_d      = r_bank_d;
    assign ext_sel     = r_ext_sel;
    assign ext_write   = r_ext_write;
    assign ext_addr    = r_ext_addr;
    assign ext_wdata   = r_wdata;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter with a synchronous two-bank SRAM model and a hand-driven external engine.
module tb_storage_arbiter;

    localparam int MEM_W       = 32;
    localparam int MEM_SZ      = 262144;
    localparam int SRAM_WORDS  = 2048;
    localparam int SRAM_BANKS  = 2;
    localparam int TIMEOUT_CYC = 1024;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          req_valid, req_ready, req_write;
    logic [31:0]                   req_addr;
    logic [MEM_W-1:0]              req_wdata;
    logic [MEM_W/8-1:0]            req_be;
    logic                          rsp_valid, rsp_ready, rsp_err;
    logic [MEM_W-1:0]              rsp_rdata;
    logic                          prog_set, prog_clr, prog_active;
    logic [SRAM_BANKS-1:0]         bank_cen;
    logic                          bank_gwen;
    logic [MEM_W/8-1:0]            bank_wen;
    logic [$clog2(SRAM_WORDS)-1:0] bank_addr;
    logic [MEM_W-1:0]              bank_d;
    logic [SRAM_BANKS*MEM_W-1:0]   bank_q = '0;
    logic                          ext_sel, ext_write, ext_ready;
    logic [31:0]                   ext_addr;
    logic [MEM_W-1:0]              ext_wdata, ext_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    storage_arbiter #(
        .MEM_W(MEM_W), .MEM_SZ(MEM_SZ), .SRAM_WORDS(SRAM_WORDS),
        .SRAM_BANKS(SRAM_BANKS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .prog_set(prog_set), .prog_clr(prog_clr), .prog_active(prog_active),
        .bank_cen(bank_cen), .bank_gwen(bank_gwen), .bank_wen(bank_wen),
        .bank_addr(bank_addr), .bank_d(bank_d), .bank_q(bank_q),
        .ext_sel(ext_sel), .ext_write(ext_write), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: q updates on the clock edge where cen is low and holds otherwise.
    logic [MEM_W-1:0] mem [SRAM_BANKS][SRAM_WORDS];
    always @(posedge clk) begin
        for (int b = 0; b < SRAM_BANKS; b++) begin
            if (!bank_cen[b]) begin
                bank_q[b*MEM_W +: MEM_W] <= mem[b][bank_addr];
                if (!bank_gwen) begin
                    for (int k = 0; k < MEM_W/8; k++)
                        if (!bank_wen[k]) mem[b][bank_addr][k*8 +: 8] <= bank_d[k*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in an IDLE cycle; returns one cycle after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        chk("req_ready_before_accept", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel_cyc;
        rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 0; prog_set = 0; prog_clr = 0; ext_ready = 0; ext_rdata = '0;
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_prog_active", 64'(prog_active), 64'(0));
        chk("rst_ext_sel", 64'(ext_sel), 64'(0));
        chk("rst_ext_write", 64'(ext_write), 64'(0));
        chk("rst_bank_cen", 64'(bank_cen), 64'(2'b11));
        chk("rst_bank_gwen", 64'(bank_gwen), 64'(1));
        chk("rst_bank_wen", 64'(bank_wen), 64'(4'hF));
        chk("rst_bank_addr", 64'(bank_addr), 64'(0));
        chk("rst_bank_d", 64'(bank_d), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("idle_req_ready", 64'(req_ready), 64'(1));

        // Full-word write to 0x4: bank 1, word 0.
        issue(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        chk("wr4_bank_cen", 64'(bank_cen), 64'(2'b01));
        chk("wr4_bank_gwen", 64'(bank_gwen), 64'(0));
        chk("wr4_bank_wen", 64'(bank_wen), 64'(4'h0));
        chk("wr4_bank_addr", 64'(bank_addr), 64'(0));
        chk("wr4_bank_d", 64'(bank_d), 64'(32'hDEADBEEF));
        chk("wr4_req_ready_busy", 64'(req_ready), 64'(0));
        tick();
        chk("wr4_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("wr4_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("wr4_rsp_err", 64'(rsp_err), 64'(0));
        chk("wr4_bank_idle", 64'(bank_cen), 64'(2'b11));
        consume();
        chk("wr4_rsp_done", 64'(rsp_valid), 64'(0));
        chk("wr4_req_ready_back", 64'(req_ready), 64'(1));

        // Read back 0x4, response held while rsp_ready is low.
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("rd4_bank_cen", 64'(bank_cen), 64'(2'b01));
        chk("rd4_bank_gwen", 64'(bank_gwen), 64'(1));
        chk("rd4_bank_addr", 64'(bank_addr), 64'(0));
        chk("rd4_no_rsp_yet", 64'(rsp_valid), 64'(0));
        tick();
        chk("rd4_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rd4_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        chk("rd4_rsp_err", 64'(rsp_err), 64'(0));
        tick();
        chk("rd4_hold_valid", 64'(rsp_valid), 64'(1));
        chk("rd4_hold_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
        consume();

        // Byte-enabled write touches bytes 0 and 2 only.
        issue(1'b1, 32'h4, 32'h11223344, 4'b0101);
        chk("wrbe_bank_wen", 64'(bank_wen), 64'(4'b1010));
        tick();
        consume();
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        chk("rdbe_rsp_rdata", 64'(rsp_rdata), 64'(32'hDE22BE44));
        consume();

        // 0x8 is word 2: bank 0, bank word 1.
        issue(1'b1, 32'h8, 32'hA5A50F0F, 4'hF);
        chk("wr8_bank_cen", 64'(bank_cen), 64'(2'b10));
        chk("wr8_bank_addr", 64'(bank_addr), 64'(1));
        tick();
        consume();
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        tick();
        chk("rd8_rsp_rdata", 64'(rsp_rdata), 64'(32'hA5A50F0F));
        consume();

        // Last scratchpad word.
        issue(1'b0, 32'h3FFC, 32'h0, 4'h0);
        chk("rdtop_bank_cen", 64'(bank_cen), 64'(2'b01));
        chk("rdtop_bank_addr", 64'(bank_addr), 64'(11'h7FF));
        chk("rdtop_ext_sel", 64'(ext_sel), 64'(0));
        tick();
        consume();

        // External read 0x10000 with ext_ready on the 5th access cycle.
        issue(1'b0, 32'h10000, 32'h0, 4'h0);
        chk("ext_sel_on", 64'(ext_sel), 64'(1));
        chk("ext_addr", 64'(ext_addr), 64'(32'h4000));
        chk("ext_write_rd", 64'(ext_write), 64'(0));
        chk("ext_bank_idle", 64'(bank_cen), 64'(2'b11));
        repeat (4) tick();
        chk("ext_sel_waiting", 64'(ext_sel), 64'(1));
        chk("ext_no_rsp_yet", 64'(rsp_valid), 64'(0));
        ext_ready = 1'b1;
        ext_rdata = 32'h12345678;
        tick();
        ext_ready = 1'b0;
        ext_rdata = '0;
        chk("ext_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("ext_rsp_rdata", 64'(rsp_rdata), 64'(32'h12345678));
        chk("ext_rsp_err", 64'(rsp_err), 64'(0));
        chk("ext_sel_off", 64'(ext_sel), 64'(0));
        consume();

        // First external address, write with immediate ready.
        issue(1'b1, 32'h4000, 32'hCAFEF00D, 4'hF);
        chk("extwr_sel", 64'(ext_sel), 64'(1));
        chk("extwr_write", 64'(ext_write), 64'(1));
        chk("extwr_addr", 64'(ext_addr), 64'(32'h1000));
        chk("extwr_wdata", 64'(ext_wdata), 64'(32'hCAFEF00D));
        ext_ready = 1'b1;
        ext_rdata = 32'hFFFFFFFF;
        tick();
        ext_ready = 1'b0;
        ext_rdata = '0;
        chk("extwr_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("extwr_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("extwr_write_off", 64'(ext_write), 64'(0));
        consume();

        // Highest legal byte address goes external.
        issue(1'b0, 32'h3FFFF, 32'h0, 4'h0);
        chk("extmax_sel", 64'(ext_sel), 64'(1));
        chk("extmax_addr", 64'(ext_addr), 64'(32'hFFFF));
        ext_ready = 1'b1;
        ext_rdata = 32'h00C0FFEE;
        tick();
        ext_ready = 1'b0;
        chk("extmax_rdata", 64'(rsp_rdata), 64'(32'h00C0FFEE));
        consume();

        // Out-of-range address.
        issue(1'b0, 32'h40000, 32'h0, 4'h0);
        chk("oor_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("oor_rsp_err", 64'(rsp_err), 64'(1));
        chk("oor_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("oor_ext_sel", 64'(ext_sel), 64'(0));
        chk("oor_bank_cen", 64'(bank_cen), 64'(2'b11));
        consume();

        // External timeout.
        issue(1'b0, 32'h10004, 32'h0, 4'h0);
        sel_cyc = 0;
        while (ext_sel && sel_cyc < 2 * TIMEOUT_CYC) begin
            sel_cyc++;
            tick();
        end
        chk("tmo_sel_cycles", 64'(sel_cyc), 64'(TIMEOUT_CYC));
        chk("tmo_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("tmo_rsp_err", 64'(rsp_err), 64'(1));
        chk("tmo_rsp_rdata", 64'(rsp_rdata), 64'(0));
        consume();

        // prog_set during an external read takes effect after the response is consumed.
        issue(1'b0, 32'h10008, 32'h0, 4'h0);
        prog_set = 1'b1;
        tick();
        prog_set = 1'b0;
        chk("prog_mid_ext", 64'(prog_active), 64'(0));
        ext_ready = 1'b1;
        ext_rdata = 32'h0BADF00D;
        tick();
        ext_ready = 1'b0;
        ext_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk("prog_hold_active", 64'(prog_active), 64'(0));
            chk("prog_hold_valid", 64'(rsp_valid), 64'(1));
            chk("prog_hold_rdata", 64'(rsp_rdata), 64'(32'h0BADF00D));
            tick();
        end
        consume();
        chk("prog_entered", 64'(prog_active), 64'(1));
        chk("prog_req_ready", 64'(req_ready), 64'(0));
        chk("prog_ext_sel", 64'(ext_sel), 64'(0));
        chk("prog_rsp_valid", 64'(rsp_valid), 64'(0));
        req_valid = 1'b1;
        req_addr  = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("prog_bank_cen", 64'(bank_cen), 64'(2'b11));
        chk("prog_still", 64'(prog_active), 64'(1));
        prog_set = 1'b1;
        prog_clr = 1'b1;
        tick();
        prog_set = 1'b0;
        prog_clr = 1'b0;
        chk("prog_both_exit", 64'(prog_active), 64'(0));
        chk("prog_both_ready", 64'(req_ready), 64'(1));

        // prog_set from IDLE, then prog_clr; then both together in IDLE.
        prog_set = 1'b1;
        tick();
        prog_set = 1'b0;
        chk("prog_idle_enter", 64'(prog_active), 64'(1));
        chk("prog_idle_ready", 64'(req_ready), 64'(0));
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
        chk("prog_idle_exit", 64'(prog_active), 64'(0));
        prog_set = 1'b1;
        prog_clr = 1'b1;
        tick();
        prog_set = 1'b0;
        prog_clr = 1'b0;
        chk("prog_idle_both", 64'(prog_active), 64'(0));

        // Asynchronous reset in the middle of an external access.
        issue(1'b0, 32'h1000C, 32'h0, 4'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_ext_sel", 64'(ext_sel), 64'(0));
        chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        chk("arst_no_rsp", 64'(rsp_valid), 64'(0));
        chk("arst_req_ready", 64'(req_ready), 64'(1));
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        tick();
        chk("arst_after_rdata", 64'(rsp_rdata), 64'(32'hDE22BE44));
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
